// File: rtl/vending_pkg.sv
// ----------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the coin acceptor front end and the vending FSM.
//   COIN_*        : 2-bit coin codes on the acceptor -> vending FSM interface
//   acc_state_t   : coin acceptor state encoding (2'b11 is unused and
//                   recovers to WAIT_RELEASE)
// ----------------------------------------------------------------------------
package vending_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_05   = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        WAIT_RELEASE = 2'b01,
        LOCKOUT      = 2'b10
    } acc_state_t;

endpackage

// File: rtl/coin_debounce.sv
// ----------------------------------------------------------------------------
// coin_debounce
// One coin-sensor channel: 2-flop synchronizer, debounce counter and a
// one-cycle rising-edge pulse on the debounced level.
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   raw   in  raw asynchronous sensor line
//   level out debounced level
//   rise  out one-cycle pulse, asserted in the same cycle level goes 0->1
// DEB_CYCLES must be at least 2.
// ----------------------------------------------------------------------------
module coin_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          rise_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            if (sync2_reg != level_reg) begin
                // The DEB_CYCLES-th consecutive differing sample flips the level.
                if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
                    level_reg <= sync2_reg;
                    rise_reg  <= sync2_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/coin_acceptor.sv
// ----------------------------------------------------------------------------
// coin_acceptor
// Front end of the vending machine: debounces the 0.5 and 1.0 coin sensors,
// enforces spacing between coins and emits a one-cycle coin code or reject.
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   sens_05    in   raw 0.5-unit sensor, high while a coin is present
//   sens_10    in   raw 1.0-unit sensor
//   enable     in   vending FSM ready for credit (sampled in IDLE only)
//   coin       out  one-cycle coin code: 00 none, 01 = 0.5, 10 = 1.0
//   reject     out  one-cycle pulse, coin sent to the return chute
//   busy       out  high whenever the acceptor is not IDLE
//   reject_cnt out  saturating count of reject pulses
// CNT_W must hold max(DEB_CYCLES, LOCKOUT_CYCLES).
// ----------------------------------------------------------------------------
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEB_CYCLES     = 4,
    parameter int LOCKOUT_CYCLES = 8,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sens_05,
    input  logic       sens_10,
    input  logic       enable,
    output logic [1:0] coin,
    output logic       reject,
    output logic       busy,
    output logic [7:0] reject_cnt
);

    // Channel 0 = 0.5 unit, channel 1 = 1.0 unit.
    logic [1:0] raw_vec;
    logic [1:0] level_vec;
    logic [1:0] rise_vec;

    assign raw_vec = {sens_10, sens_05};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            coin_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk  (clk),
                .rst  (rst),
                .raw  (raw_vec[gi]),
                .level(level_vec[gi]),
                .rise (rise_vec[gi])
            );
        end
    endgenerate

    acc_state_t       state_reg,  state_next;
    logic [CNT_W-1:0] lock_reg,   lock_next;
    logic [1:0]       coin_reg,   coin_next;
    logic             reject_reg, reject_next;
    logic [7:0]       reject_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Start in WAIT_RELEASE so a coin stuck in the slot at power-up,
            // or one interrupted by reset, is never credited.
            state_reg      <= WAIT_RELEASE;
            lock_reg       <= '0;
            coin_reg       <= COIN_NONE;
            reject_reg     <= 1'b0;
            reject_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            lock_reg   <= lock_next;
            coin_reg   <= coin_next;
            reject_reg <= reject_next;
            if (reject_next && (reject_cnt_reg != 8'hFF)) begin
                reject_cnt_reg <= reject_cnt_reg + 8'd1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        lock_next   = lock_reg;
        coin_next   = COIN_NONE;
        reject_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rise_vec == 2'b11) begin
                    // Two coins at once cannot be told apart: always reject.
                    reject_next = 1'b1;
                    state_next  = WAIT_RELEASE;
                end else if (rise_vec != 2'b00) begin
                    if (enable) begin
                        coin_next = rise_vec[0] ? COIN_05 : COIN_10;
                    end else begin
                        reject_next = 1'b1;
                    end
                    state_next = WAIT_RELEASE;
                end
            end

            WAIT_RELEASE: begin
                if (level_vec == 2'b00) begin
                    lock_next  = CNT_W'(LOCKOUT_CYCLES);
                    state_next = LOCKOUT;
                end
            end

            LOCKOUT: begin
                // A new coin wins over the counter expiring in the same cycle.
                if (rise_vec != 2'b00) begin
                    reject_next = 1'b1;
                    state_next  = WAIT_RELEASE;
                end else if (lock_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    lock_next = lock_reg - CNT_W'(1);
                end
            end

            default: begin
                state_next = WAIT_RELEASE;
            end
        endcase
    end

    assign coin       = coin_reg;
    assign reject     = reject_reg;
    assign busy       = (state_reg != IDLE);
    assign reject_cnt = reject_cnt_reg;

endmodule
